// File: rtl/adc_capture_window_if.sv
// AXI-Stream pair around the ADC capture gate.
// The ADC-facing side is s_axis_*, and the adc_driver-facing side is m_axis_*.
interface adc_capture_window_if #(
    parameter int DATA_WIDTH = 128
);
    logic [DATA_WIDTH-1:0] s_axis_tdata;
    logic                  s_axis_tvalid;
    logic                  s_axis_tready;
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_tlast;

    modport master (
        output s_axis_tdata,
        output s_axis_tvalid,
        output m_axis_tready,
        input  s_axis_tready,
        input  m_axis_tdata,
        input  m_axis_tvalid,
        input  m_axis_tlast
    );

    modport slave (
        input  s_axis_tdata,
        input  s_axis_tvalid,
        input  m_axis_tready,
        output s_axis_tready,
        output m_axis_tdata,
        output m_axis_tvalid,
        output m_axis_tlast
    );
endinterface

// File: rtl/adc_capture_window.sv
// Triggered capture gate: after an armed trigger edge, it skips D ADC beats.
// It then forwards N beats through a one-deep output register.
module adc_capture_window #(
    parameter int DATA_WIDTH = 128,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 arm,
    input  logic                 abort,
    input  logic                 trigger,
    input  logic [CNT_WIDTH-1:0] delay_beats,
    input  logic [CNT_WIDTH-1:0] capture_beats,
    adc_capture_window_if.slave  axis,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARMED   = 3'd1;
    localparam logic [2:0] S_DELAY   = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    logic [2:0]            state;
    logic                  trig_d;
    logic [CNT_WIDTH-1:0]  dly_q;
    logic [CNT_WIDTH-1:0]  len_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  last_q;

    logic trig_edge;
    logic arm_ok;
    logic beat;
    logic cap_beat;
    logic last_beat;
    logic load;
    logic drop;

    assign trig_edge = trigger & ~trig_d;
    assign arm_ok    = (state == S_IDLE) & arm & ~abort
                     & (capture_beats != '0);
    assign beat      = axis.s_axis_tvalid;
    assign cap_beat  = (state == S_CAPTURE) & beat & ~abort;
    assign last_beat = (cnt_q == len_q - ONE);
    assign load      = cap_beat & (~valid_q | axis.m_axis_tready);
    assign drop      = cap_beat & valid_q & ~axis.m_axis_tready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= S_IDLE;
            trig_d <= 1'b0;
            dly_q  <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
        end else begin
            trig_d <= trigger;
            if (abort) begin
                state <= S_IDLE;
                cnt_q <= '0;
            end else begin
                unique case (state)
                    S_IDLE: if (arm_ok) begin
                        state <= S_ARMED;
                        dly_q <= delay_beats;
                        len_q <= capture_beats;
                        cnt_q <= '0;
                    end
                    S_ARMED: if (trig_edge) begin
                        state <= (dly_q != '0) ? S_DELAY : S_CAPTURE;
                    end
                    // The D-th valid beat itself is discarded
                    S_DELAY: if (beat) begin
                        if (cnt_q == dly_q - ONE) begin
                            state <= S_CAPTURE;
                            cnt_q <= '0;
                        end else begin
                            cnt_q <= cnt_q + ONE;
                        end
                    end
                    S_CAPTURE: if (beat) begin
                        if (last_beat) begin
                            state <= S_DONE;
                            cnt_q <= '0;
                        end else begin
                            cnt_q <= cnt_q + ONE;
                        end
                    end
                    S_DONE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // A dropped beat leaves the held beat untouched
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (abort) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (load) begin
            data_q  <= axis.s_axis_tdata;
            valid_q <= 1'b1;
            last_q  <= last_beat;
        end else if (axis.m_axis_tready) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (arm_ok) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end

    assign axis.s_axis_tready = 1'b1;
    assign axis.m_axis_tdata  = data_q;
    assign axis.m_axis_tvalid = valid_q;
    assign axis.m_axis_tlast  = last_q;

    assign busy = (state == S_ARMED) | (state == S_DELAY)
                | (state == S_CAPTURE);
    assign done = (state == S_DONE);
endmodule
